// File: rtl/xbar_switch_alloc.sv
// Switch allocator + crossbar for a 5-port router: decodes head-flit destinations,
// arbitrates round-robin per output with backpressure, and registers one flit per output.
module xbar_switch_alloc #(
  parameter int unsigned NUM_PORTS      = 5,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned DEST_WIDTH     = 3,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             in_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
  output logic [NUM_PORTS-1:0]             in_pop,
  input  logic [NUM_PORTS-1:0]             out_full,
  output logic [NUM_PORTS-1:0]             out_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  out_data,
  output logic [DROP_CNT_WIDTH-1:0]        drop_count
);

  localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0][PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]                 out_valid_q, out_valid_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0]      out_data_q, out_data_d;
  logic [DROP_CNT_WIDTH-1:0]            drop_count_q, drop_count_d;
  logic [NUM_PORTS-1:0][DEST_WIDTH-1:0] dest;
  logic [NUM_PORTS-1:0]                 drop;
  logic [NUM_PORTS-1:0]                 pop;

  // Destination decode; out-of-range destinations are discarded on sight.
  always_comb begin : decode
    dest = '0;
    drop = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      dest[i] = in_data[i*DATA_WIDTH + DATA_WIDTH - 1 -: DEST_WIDTH];
      drop[i] = in_valid[i] && (32'(dest[i]) >= NUM_PORTS);
    end
  end

  // Per-output round-robin search starting at rr_ptr; a full output grants nothing.
  always_comb begin : arbitrate
    logic             found;
    logic [PTR_W-1:0] idx;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = '0;
    out_data_d  = out_data_q;
    pop         = drop;
    found       = 1'b0;
    idx         = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        idx = PTR_W'((32'(rr_ptr_q[o]) + k) % NUM_PORTS);
        if (!found && !out_full[o] && in_valid[idx] && (32'(dest[idx]) == o)) begin
          found                                 = 1'b1;
          out_valid_d[o]                        = 1'b1;
          out_data_d[o*DATA_WIDTH +: DATA_WIDTH] = in_data[32'(idx)*DATA_WIDTH +: DATA_WIDTH];
          rr_ptr_d[o]                           = PTR_W'((32'(idx) + 1) % NUM_PORTS);
          pop[idx]                              = 1'b1;
        end
      end
    end
  end

  // Saturating drop counter; several drops in one cycle each add one.
  always_comb begin : drop_cnt
    drop_count_d = drop_count_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (drop[i] && (drop_count_d != '1)) begin
        drop_count_d = drop_count_d + DROP_CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q     <= '0;
      out_valid_q  <= '0;
      out_data_q   <= '0;
      drop_count_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign in_pop     = reset ? pop : '0;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_xbar_switch_alloc.sv
// Bench for xbar_switch_alloc: directed table, hand sequences for multi-cycle cases,
// and a randomized run against a queue-based reference model.
module tb_xbar_switch_alloc;
  localparam int N  = 5;
  localparam int W  = 16;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     in_valid, in_pop, out_full, out_valid;
  logic [N*W-1:0]   in_data, out_data;
  logic [CW-1:0]    drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xbar_switch_alloc dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_pop    (in_pop),
    .out_full  (out_full),
    .out_valid (out_valid),
    .out_data  (out_data),
    .drop_count(drop_count)
  );

  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   full;
    logic [N-1:0]   exp_pop;
    logic [N-1:0]   exp_oval;
    logic [N*W-1:0] exp_odata;
    logic [CW-1:0]  exp_drop;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [N*W-1:0] pk(input logic [W-1:0] a0, a1, a2, a3, a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic [N-1:0] f);
    in_valid = v;
    in_data  = d;
    out_full = f;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Reference model state for the random phase
  int             rr[N];
  int             dcnt;
  logic [N-1:0]   m_oval;
  logic [W-1:0]   m_odata[N];
  logic [W-1:0]   q[N][$];

  initial begin
    logic [N-1:0]   exp_pop;
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic [N-1:0]   f;
    logic [N*W-1:0] mo;
    logic [N-1:0]   rr_pops[6];
    int             gidx[6];
    int             dst;

    // Table of single-cycle vectors applied back to back from reset.
    tbl[0] = '{5'b00001, pk(16'h4ABC, 0, 0, 0, 0), 5'b00000, 5'b00001, 5'b00100,
               pk(0, 0, 16'h4ABC, 0, 0), 8'd0};
    tbl[1] = '{5'b00000, '0, 5'b00000, 5'b00000, 5'b00000,
               pk(0, 0, 16'h4ABC, 0, 0), 8'd0};
    tbl[2] = '{5'b11111, pk(16'h2001, 16'h4002, 16'h6003, 16'h8004, 16'h0005), 5'b00000,
               5'b11111, 5'b11111, pk(16'h0005, 16'h2001, 16'h4002, 16'h6003, 16'h8004), 8'd0};
    tbl[3] = '{5'b01000, pk(0, 0, 0, 16'hE000, 0), 5'b00000, 5'b01000, 5'b00000,
               pk(16'h0005, 16'h2001, 16'h4002, 16'h6003, 16'h8004), 8'd1};
    tbl[4] = '{5'b01010, pk(0, 16'h0011, 0, 16'h0033, 0), 5'b00001, 5'b00000, 5'b00000,
               pk(16'h0005, 16'h2001, 16'h4002, 16'h6003, 16'h8004), 8'd1};
    tbl[5] = '{5'b01010, pk(0, 16'h0011, 0, 16'h0033, 0), 5'b00000, 5'b00010, 5'b00001,
               pk(16'h0011, 16'h2001, 16'h4002, 16'h6003, 16'h8004), 8'd1};

    // Reset: in_pop gated while reset is low even with valid inputs
    reset = 1'b0;
    drive(5'b11111, pk(16'h0000, 16'h2000, 16'hE000, 16'h6000, 16'h8000), '0);
    #3;
    check("pop_in_reset", N*W'(in_pop), '0);
    @(posedge clk);
    #1;
    check("rst_oval", N*W'(out_valid), '0);
    check("rst_odata", out_data, '0);
    check("rst_drop", N*W'(drop_count), '0);
    drive('0, '0, '0);
    reset = 1'b1;

    for (int r = 0; r < 6; r++) begin
      drive(tbl[r].valid, tbl[r].data, tbl[r].full);
      #3;
      check($sformatf("tbl%0d_pop", r), N*W'(in_pop), N*W'(tbl[r].exp_pop));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_oval", r), N*W'(out_valid), N*W'(tbl[r].exp_oval));
      check($sformatf("tbl%0d_odata", r), out_data, tbl[r].exp_odata);
      check($sformatf("tbl%0d_drop", r), N*W'(drop_count), N*W'(tbl[r].exp_drop));
    end

    // Round robin on output 4 among inputs 0,1,3 starting from pointer 0
    do_reset();
    rr_pops = '{5'b00001, 5'b00010, 5'b01000, 5'b00001, 5'b00010, 5'b01000};
    gidx    = '{0, 1, 3, 0, 1, 3};
    for (int c = 0; c < 6; c++) begin
      drive(5'b01011, pk(16'h8000, 16'h8001, 0, 16'h8003, 0), '0);
      #3;
      check($sformatf("rr%0d_pop", c), N*W'(in_pop), N*W'(rr_pops[c]));
      @(posedge clk);
      #1;
      check($sformatf("rr%0d_oval", c), N*W'(out_valid), N*W'(5'b10000));
      check($sformatf("rr%0d_odata", c), N*W'(out_data[4*W +: W]), N*W'(16'h8000 + 16'(gidx[c])));
    end

    // Backpressure on output 1 for three cycles
    for (int c = 0; c < 3; c++) begin
      drive(5'b00100, pk(0, 0, 16'h2222, 0, 0), 5'b00010);
      #3;
      check($sformatf("full%0d_pop", c), N*W'(in_pop), '0);
      @(posedge clk);
      #1;
      check($sformatf("full%0d_oval", c), N*W'(out_valid), '0);
    end
    drive(5'b00100, pk(0, 0, 16'h2222, 0, 0), 5'b00000);
    #3;
    check("full_release_pop", N*W'(in_pop), N*W'(5'b00100));
    @(posedge clk);
    #1;
    check("full_release_oval", N*W'(out_valid), N*W'(5'b00010));
    check("full_release_odata", N*W'(out_data[1*W +: W]), N*W'(16'h2222));
    drive('0, '0, '0);
    @(posedge clk);
    #1;
    check("strobe_one_cycle", N*W'(out_valid), '0);
    check("idle_hold_odata", N*W'(out_data[1*W +: W]), N*W'(16'h2222));

    // Illegal destination for 300 cycles: drop counter saturates
    for (int c = 0; c < 300; c++) begin
      drive(5'b01000, pk(0, 0, 0, 16'hE000, 0), '0);
      #3;
      check("drop_pop", N*W'(in_pop), N*W'(5'b01000));
      @(posedge clk);
      #1;
      check("drop_oval", N*W'(out_valid), '0);
    end
    check("drop_sat", N*W'(drop_count), N*W'(8'd255));

    // Async reset mid-cycle while outputs 1 and 2 strobe
    drive(5'b00110, pk(0, 16'h2111, 16'h4222, 0, 0), '0);
    @(posedge clk);
    #1;
    check("pre_rst_oval", N*W'(out_valid), N*W'(5'b00110));
    drive(5'b01001, pk(16'h4000, 0, 0, 16'h4003, 0), '0);
    #2;
    reset = 1'b0;
    #1;
    check("async_oval", N*W'(out_valid), '0);
    check("async_odata", out_data, '0);
    check("async_drop", N*W'(drop_count), '0);
    check("async_pop", N*W'(in_pop), '0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #3;
    check("post_rst_first_grant", N*W'(in_pop), N*W'(5'b00001));
    @(posedge clk);
    #1;
    check("post_rst_odata", N*W'(out_data[2*W +: W]), N*W'(16'h4000));

    // Randomized phase against the reference model
    drive('0, '0, '0);
    do_reset();
    for (int i = 0; i < N; i++) begin
      rr[i] = 0;
      m_odata[i] = '0;
      q[i].delete();
    end
    dcnt   = 0;
    m_oval = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) mo[i*W +: W] = m_odata[i];
      check("rnd_oval", N*W'(out_valid), N*W'(m_oval));
      check("rnd_odata", out_data, mo);
      check("rnd_drop", N*W'(drop_count), N*W'(8'(dcnt)));
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 3 && $urandom_range(0, 1) == 1) begin
          dst = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
          q[i].push_back({3'(dst), 13'($urandom)});
        end
      end
      v = '0;
      d = '0;
      for (int i = 0; i < N; i++) begin
        if (q[i].size() > 0) begin
          v[i] = 1'b1;
          d[i*W +: W] = q[i][0];
        end
      end
      for (int o = 0; o < N; o++) f[o] = ($urandom_range(0, 3) == 0);
      drive(v, d, f);
      exp_pop = '0;
      for (int i = 0; i < N; i++) begin
        if (v[i] && int'(d[i*W + W - 1 -: 3]) >= N) begin
          exp_pop[i] = 1'b1;
          if (dcnt < 255) dcnt++;
        end
      end
      m_oval = '0;
      for (int o = 0; o < N; o++) begin
        if (!f[o]) begin
          for (int k = 0; k < N; k++) begin
            int s;
            s = (rr[o] + k) % N;
            if (m_oval[o] == 1'b0 && v[s] && int'(d[s*W + W - 1 -: 3]) == o) begin
              m_oval[o]  = 1'b1;
              m_odata[o] = d[s*W +: W];
              exp_pop[s] = 1'b1;
              rr[o]      = (s + 1) % N;
            end
          end
        end
      end
      #3;
      check("rnd_pop", N*W'(in_pop), N*W'(exp_pop));
      for (int i = 0; i < N; i++) if (exp_pop[i]) void'(q[i].pop_front());
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
